// File: rtl/fb_read_scheduler_if.sv
// rtl/fb_read_scheduler_if.sv - memory read port and display FIFO write port bundle
//
// Purpose : groups the burst read port (request/ack/address/length/data) and the
//           display FIFO write side into one bundle.
// Modports: master - the scheduler (drives requests and FIFO writes)
//           slave  - memory read port plus FIFO (acks, returns data, reports level)
// Signals : rd_req/rd_ack/rd_addr/rd_len  burst request handshake
//           rd_data_valid/rd_data          returned read beats
//           fifo_flush/fifo_wr/fifo_din    FIFO clear and write port
//           fifo_wrusedw                   FIFO fill level, write side
interface fb_read_scheduler_if #(
   parameter int ADDR_W  = 28,
   parameter int LEVEL_W = 11
);
   logic               rd_req;
   logic               rd_ack;
   logic [ADDR_W-1:0]  rd_addr;
   logic [8:0]         rd_len;
   logic               rd_data_valid;
   logic [31:0]        rd_data;
   logic               fifo_flush;
   logic               fifo_wr;
   logic [31:0]        fifo_din;
   logic [LEVEL_W-1:0] fifo_wrusedw;

   modport master (
      output rd_req, rd_addr, rd_len, fifo_flush, fifo_wr, fifo_din,
      input  rd_ack, rd_data_valid, rd_data, fifo_wrusedw
   );

   modport slave (
      input  rd_req, rd_addr, rd_len, fifo_flush, fifo_wr, fifo_din,
      output rd_ack, rd_data_valid, rd_data, fifo_wrusedw
   );
endinterface

// File: rtl/fb_read_scheduler.sv
// rtl/fb_read_scheduler.sv - fills the display read FIFO from a double-buffered frame store
//
// Purpose : on each display frame start (rd_load), flushes the FIFO, selects the most
//           recently completed write bank and fetches one full source frame in
//           fixed-length bursts whenever the FIFO has room. One burst outstanding.
// Ports   : mem_clock, reset_n   clock and asynchronous active-low reset
//           rd_load               display vsync level (asynchronous, synchronised here)
//           wr_frame_done/wr_bank writer finished a frame in wr_bank (one-cycle pulse)
//           bus (master)          burst read port and display FIFO write port
//           rd_bank               bank currently being read
//           frame_active          high from FLUSH until the last frame word is written
//           timeout_err           sticky burst timeout flag
// Option  : FB_RD_TIMEOUT_EN - abort a burst that has not completed within TIMEOUT
//           cycles of entering DATA; without it timeout_err is tied 0.
module fb_read_scheduler #(
   parameter int                H_PIXELS    = 800,
   parameter int                V_LINES     = 480,
   parameter int                BURST_LEN   = 64,
   parameter int                FIFO_DEPTH  = 1024,
   parameter int                LEVEL_W     = 11,
   parameter int                ADDR_W      = 28,
   parameter logic [ADDR_W-1:0] FRAME_BASE0 = '0,
   parameter logic [ADDR_W-1:0] FRAME_BASE1 = 'h0200000,
   parameter int                TIMEOUT     = 4096
) (
   input  logic                mem_clock,
   input  logic                reset_n,
   input  logic                rd_load,
   input  logic                wr_frame_done,
   input  logic                wr_bank,
   fb_read_scheduler_if.master bus,
   output logic                rd_bank,
   output logic                frame_active,
   output logic                timeout_err
);

   localparam int FRAME_WORDS = H_PIXELS * V_LINES;
   localparam int IDX_W       = $clog2(FRAME_WORDS + 1);
   localparam int ROOM_MAX    = FIFO_DEPTH - BURST_LEN - 4;

   typedef enum logic [2:0] {IDLE, FLUSH, WAIT_ROOM, REQ, DATA, DONE} state_t;

   state_t           state, state_nxt;
   logic             load_s1, load_s2, load_s3;
   logic             load_rise;
   logic             restart_pend;
   logic             restart_now;
   logic             take_restart;
   logic             bank_valid;
   logic             next_bank;
   logic [IDX_W-1:0] word_idx;
   logic [8:0]       beat_cnt;
   logic             beat_in;
   logic             last_beat;
   logic             frame_end;
   logic             room_ok;
   logic             tmo_fire;
   logic [31:0]      remaining;
   logic [8:0]       len_calc;
   logic [ADDR_W-1:0] base_sel;

   // The edge detected this cycle counts as pending, so a restart decision can be
   // taken in the same cycle the edge appears (3 cycles after the rd_load edge).
   assign load_rise   = load_s2 & ~load_s3;
   assign restart_now = restart_pend | load_rise;

   assign beat_in   = (state == DATA) && bus.rd_data_valid;
   assign last_beat = beat_in && (beat_cnt == 9'd1);
   assign frame_end = last_beat && (word_idx == IDX_W'(FRAME_WORDS - 1));
   assign room_ok   = (bus.fifo_wrusedw <= LEVEL_W'(ROOM_MAX));

   assign remaining = 32'(FRAME_WORDS) - 32'(word_idx);
   assign len_calc  = (remaining < 32'(BURST_LEN)) ? 9'(remaining) : 9'(BURST_LEN);
   assign base_sel  = rd_bank ? FRAME_BASE1 : FRAME_BASE0;

`ifdef FB_RD_TIMEOUT_EN
   localparam int TMO_W = $clog2(TIMEOUT + 1);

   logic [TMO_W-1:0] tmo_cnt;
   logic             tmo_err_q;

   // A beat landing on the final cycle still completes the burst normally.
   assign tmo_fire    = (state == DATA) && !last_beat && (tmo_cnt == TMO_W'(TIMEOUT - 1));
   assign timeout_err = tmo_err_q;

   always_ff @(posedge mem_clock or negedge reset_n) begin
      if (!reset_n) begin
         tmo_cnt   <= '0;
         tmo_err_q <= 1'b0;
      end else begin
         if ((state == REQ) && bus.rd_ack) begin
            tmo_cnt <= '0;
         end else if (state == DATA) begin
            tmo_cnt <= tmo_cnt + 1'b1;
         end
         if (tmo_fire) begin
            tmo_err_q <= 1'b1;
         end
      end
   end
`else
   assign tmo_fire    = 1'b0;
   assign timeout_err = 1'b0;
`endif

   always_ff @(posedge mem_clock or negedge reset_n) begin
      if (!reset_n) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   always_comb begin
      state_nxt      = state;
      take_restart   = 1'b0;
      bus.rd_req     = 1'b0;
      bus.fifo_flush = 1'b0;
      case (state)
         IDLE, DONE: begin
            if (restart_now) begin
               state_nxt    = FLUSH;
               take_restart = 1'b1;
            end
         end
         FLUSH: begin
            bus.fifo_flush = 1'b1;
            state_nxt      = WAIT_ROOM;
         end
         WAIT_ROOM: begin
            if (restart_now) begin
               state_nxt    = FLUSH;
               take_restart = 1'b1;
            end else if (room_ok) begin
               state_nxt = REQ;
            end
         end
         REQ: begin
            bus.rd_req = 1'b1;
            if (bus.rd_ack) begin
               state_nxt = DATA;
            end
         end
         DATA: begin
            // A pending restart waits for the burst boundary; bursts are never cut short.
            if (last_beat) begin
               if (restart_now) begin
                  state_nxt    = FLUSH;
                  take_restart = 1'b1;
               end else if (frame_end) begin
                  state_nxt = DONE;
               end else begin
                  state_nxt = WAIT_ROOM;
               end
            end else if (tmo_fire) begin
               state_nxt = IDLE;
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge mem_clock or negedge reset_n) begin
      if (!reset_n) begin
         load_s1      <= 1'b0;
         load_s2      <= 1'b0;
         load_s3      <= 1'b0;
         restart_pend <= 1'b0;
         bank_valid   <= 1'b0;
         next_bank    <= 1'b0;
         rd_bank      <= 1'b0;
         word_idx     <= '0;
         beat_cnt     <= '0;
         bus.rd_addr  <= '0;
         bus.rd_len   <= '0;
         bus.fifo_wr  <= 1'b0;
         bus.fifo_din <= '0;
         frame_active <= 1'b0;
      end else begin
         load_s1 <= rd_load;
         load_s2 <= load_s1;
         load_s3 <= load_s2;

         if (take_restart) begin
            restart_pend <= 1'b0;
         end else if (load_rise) begin
            restart_pend <= 1'b1;
         end

         if (wr_frame_done) begin
            next_bank  <= wr_bank;
            bank_valid <= 1'b1;
         end

         // A completion pulse coinciding with the restart decision wins over the latch.
         if (take_restart) begin
            if (wr_frame_done) begin
               rd_bank <= wr_bank;
            end else if (bank_valid) begin
               rd_bank <= next_bank;
            end
         end

         if (take_restart) begin
            word_idx <= '0;
         end else if (beat_in) begin
            word_idx <= word_idx + 1'b1;
         end

         if ((state == REQ) && bus.rd_ack) begin
            beat_cnt <= bus.rd_len;
         end else if (beat_in) begin
            beat_cnt <= beat_cnt - 1'b1;
         end

         // Address and length are captured on entry to REQ and held until the ack.
         if ((state == WAIT_ROOM) && (state_nxt == REQ)) begin
            bus.rd_addr <= base_sel + ADDR_W'({word_idx, 2'b00});
            bus.rd_len  <= len_calc;
         end

         bus.fifo_wr <= beat_in;
         if (beat_in) begin
            bus.fifo_din <= bus.rd_data;
         end

         if (take_restart) begin
            frame_active <= 1'b1;
         end else if (frame_end || tmo_fire) begin
            frame_active <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_fb_read_scheduler.sv
// tb/tb_fb_read_scheduler.sv - directed bench with a frame-level read model for fb_read_scheduler
`timescale 1ns/1ps
module tb_fb_read_scheduler;

   localparam int              FRAME   = 100;
   localparam int              BURST   = 64;
   localparam int              ADDR_W  = 28;
   localparam int              LEVEL_W = 11;
   localparam logic [31:0]     BASE0   = 32'h0;
   localparam logic [31:0]     BASE1   = 32'h0200000;

   logic mem_clock     = 1'b0;
   logic reset_n       = 1'b0;
   logic rd_load       = 1'b0;
   logic wr_frame_done = 1'b0;
   logic wr_bank       = 1'b0;
   logic rd_bank;
   logic frame_active;
   logic timeout_err;

   fb_read_scheduler_if #(.ADDR_W(ADDR_W), .LEVEL_W(LEVEL_W)) bus ();

   fb_read_scheduler #(
      .H_PIXELS   (10),
      .V_LINES    (10),
      .BURST_LEN  (BURST),
      .FIFO_DEPTH (1024),
      .LEVEL_W    (LEVEL_W),
      .ADDR_W     (ADDR_W),
      .FRAME_BASE0(28'h0),
      .FRAME_BASE1(28'h0200000),
      .TIMEOUT    (100)
   ) dut (
      .mem_clock    (mem_clock),
      .reset_n      (reset_n),
      .rd_load      (rd_load),
      .wr_frame_done(wr_frame_done),
      .wr_bank      (wr_bank),
      .bus          (bus),
      .rd_bank      (rd_bank),
      .frame_active (frame_active),
      .timeout_err  (timeout_err)
   );

   always #5 mem_clock = ~mem_clock;

   int tests = 0;
   int fails = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got 'h%0h, expected 'h%0h", name, act, exp);
      end
   endtask

   // Frame-level model state
   int          model_idx        = 0;
   logic        model_bank       = 1'b0;
   logic        latest_bank      = 1'b0;
   int          frame_words      = 0;
   int          last_frame_words = 0;
   int          flush_cnt        = 0;
   int          req_cnt          = 0;
   logic [31:0] log_addr[$];
   int          log_len[$];
   bit          req_open         = 1'b0;
   logic [31:0] cur_addr         = '0;
   int          cur_len          = 0;
   int          cyc              = 0;
   int          data_entry_cyc   = 0;
   bit          prev_exp_wr      = 1'b0;
   logic [31:0] prev_exp_din     = '0;
   bit          prev_flush       = 1'b0;

   // Responder controls
   int          beat_limit = 1000;
   int          beat_num   = 0;
   bit          beat_ok    = 1'b0;

   function automatic logic [31:0] base_of(input logic b);
      return b ? BASE1 : BASE0;
   endfunction

   function automatic logic [31:0] get_addr(input int i);
      return (i < log_addr.size()) ? log_addr[i] : 32'hFFFF_FFFF;
   endfunction

   function automatic int get_len(input int i);
      return (i < log_len.size()) ? log_len[i] : -1;
   endfunction

   // Compare process: every cycle, DUT outputs against the frame model
   always @(negedge mem_clock) begin
      cyc++;
      check("fifo_wr", bus.fifo_wr, prev_exp_wr);
      if (prev_exp_wr) begin
         check("fifo_din", bus.fifo_din, prev_exp_din);
         frame_words++;
         check("frame_active_at_write", frame_active, (frame_words < FRAME));
      end
      prev_exp_wr  = bus.rd_data_valid && beat_ok;
      prev_exp_din = bus.rd_data;

      if (bus.fifo_flush) begin
         check("flush_one_cycle", prev_flush, 1'b0);
         flush_cnt++;
         last_frame_words = frame_words;
         frame_words      = 0;
         model_idx        = 0;
         model_bank       = latest_bank;
      end
      prev_flush = bus.fifo_flush;

      if (bus.rd_req && !req_open) begin
         req_open = 1'b1;
         req_cnt++;
         cur_addr = 32'(bus.rd_addr);
         cur_len  = int'(bus.rd_len);
         log_addr.push_back(cur_addr);
         log_len.push_back(cur_len);
         check("req_within_frame", (model_idx < FRAME), 1'b1);
         check("rd_addr", bus.rd_addr, base_of(model_bank) + 32'(model_idx * 4));
         check("rd_len", bus.rd_len,
               32'(((FRAME - model_idx) < BURST) ? (FRAME - model_idx) : BURST));
         check("rd_bank", rd_bank, model_bank);
      end else if (bus.rd_req) begin
         check("rd_addr_hold", bus.rd_addr, cur_addr);
         check("rd_len_hold", bus.rd_len, cur_len);
      end else if (req_open) begin
         req_open       = 1'b0;
         model_idx      = model_idx + cur_len;
         data_entry_cyc = cyc;
      end
   end

   // Memory responder: ack one cycle after the request, then stream the burst
   initial begin
      logic [27:0] a;
      int          n;
      bus.rd_ack        = 1'b0;
      bus.rd_data_valid = 1'b0;
      bus.rd_data       = '0;
      forever begin
         @(negedge mem_clock);
         if (bus.rd_req === 1'b1) begin
            a = bus.rd_addr;
            n = int'(bus.rd_len);
            @(posedge mem_clock); #1;
            bus.rd_ack = 1'b1;
            @(posedge mem_clock); #1;
            bus.rd_ack = 1'b0;
            for (int b = 0; b < n && b < beat_limit; b++) begin
               beat_num          = b + 1;
               bus.rd_data_valid = 1'b1;
               bus.rd_data       = 32'hC000_0000 | (32'(a >> 2) + 32'(b));
               beat_ok           = 1'b1;
               @(posedge mem_clock); #1;
            end
            bus.rd_data_valid = 1'b0;
            beat_ok           = 1'b0;
         end
      end
   end

   task automatic tick();
      @(negedge mem_clock); #1;
   endtask

   task automatic pulse_load();
      rd_load = 1'b1;
      repeat (6) tick();
      rd_load = 1'b0;
      repeat (2) tick();
   endtask

   task automatic wait_frame(input int flushes, input string name);
      int n = 0;
      while (!(flush_cnt == flushes && frame_words == FRAME) && n < 3000) begin
         tick();
         n++;
      end
      check({name, "_complete"}, (flush_cnt == flushes && frame_words == FRAME), 1'b1);
   endtask

   initial begin
      int r0;
      int n;
      bus.fifo_wrusedw = '0;

      // Reset values
      repeat (3) tick();
      check("rst_fifo_flush", bus.fifo_flush, 1'b0);
      check("rst_fifo_wr", bus.fifo_wr, 1'b0);
      check("rst_fifo_din", bus.fifo_din, 32'h0);
      check("rst_rd_req", bus.rd_req, 1'b0);
      check("rst_rd_addr", bus.rd_addr, 32'h0);
      check("rst_rd_len", bus.rd_len, 32'h0);
      check("rst_rd_bank", rd_bank, 1'b0);
      check("rst_frame_active", frame_active, 1'b0);
      check("rst_timeout_err", timeout_err, 1'b0);
      @(posedge mem_clock); #1;
      reset_n = 1'b1;

      // Stray read data while idle must not reach the FIFO
      repeat (2) tick();
      @(posedge mem_clock); #1;
      bus.rd_data_valid = 1'b1;
      bus.rd_data       = 32'hDEAD_BEEF;
      @(posedge mem_clock); #1;
      bus.rd_data_valid = 1'b0;
      repeat (3) tick();
      check("idle_no_req", req_cnt, 0);
      check("idle_no_flush", flush_cnt, 0);

      // Frame A: bank 0, 64 words at 0 then 36 words at 256, then DONE
      pulse_load();
      wait_frame(1, "frame_a");
      check("a_flush_count", flush_cnt, 1);
      check("a_rd_bank", rd_bank, 1'b0);
      check("a_req0_addr", get_addr(0), 32'd0);
      check("a_req0_len", get_len(0), 64);
      check("a_req1_addr", get_addr(1), 32'd256);
      check("a_req1_len", get_len(1), 36);
      repeat (40) tick();
      check("a_done_no_more_req", req_cnt, 2);
      check("a_frame_active_low", frame_active, 1'b0);

      // Frame B: writer completes bank 1 mid-frame; B stays on bank 0
      pulse_load();
      n = 0;
      while (!(req_cnt == 3 && !req_open) && n < 500) begin tick(); n++; end
      check("b_first_burst_acked", (req_cnt == 3 && !req_open), 1'b1);
      wr_bank       = 1'b1;
      wr_frame_done = 1'b1;
      tick();
      wr_frame_done = 1'b0;
      latest_bank   = 1'b1;
      wait_frame(2, "frame_b");
      check("b_req0_addr", get_addr(2), 32'd0);
      check("b_req1_addr", get_addr(3), 32'd256);
      check("b_rd_bank", rd_bank, 1'b0);

      // Frame C: switches to bank 1
      pulse_load();
      wait_frame(3, "frame_c");
      check("c_req0_addr", get_addr(4), 32'h0200000);
      check("c_req1_addr", get_addr(5), 32'h0200100);
      check("c_rd_bank", rd_bank, 1'b1);

      // Frame D: FIFO level 957 blocks requests, 956 releases them next cycle
      bus.fifo_wrusedw = 11'd957;
      r0 = req_cnt;
      pulse_load();
      repeat (40) tick();
      check("d_flush_count", flush_cnt, 4);
      check("d_blocked_req_cnt", req_cnt, r0);
      check("d_blocked_rd_req", bus.rd_req, 1'b0);
      @(posedge mem_clock); #1;
      bus.fifo_wrusedw = 11'd956;
      @(negedge mem_clock); #1;
      check("d_rd_req_same_cycle", bus.rd_req, 1'b0);
      @(negedge mem_clock); #1;
      check("d_rd_req_next_cycle", bus.rd_req, 1'b1);
      wait_frame(4, "frame_d");
      bus.fifo_wrusedw = '0;

      // Frame E: rd_load edge during beat 10 of the first burst
      r0 = req_cnt;
      pulse_load();
      n = 0;
      while (!(req_cnt == r0 + 1 && beat_num == 10) && n < 500) begin tick(); n++; end
      check("e_reached_beat10", (req_cnt == r0 + 1 && beat_num == 10), 1'b1);
      rd_load = 1'b1;
      repeat (6) tick();
      rd_load = 1'b0;
      n = 0;
      while (flush_cnt != 6 && n < 500) begin tick(); n++; end
      check("e_restart_flush", flush_cnt, 6);
      check("e_full_burst_written", last_frame_words, 64);
      wait_frame(6, "frame_f");
      check("f_req0_addr", get_addr(r0 + 1), 32'h0200000);
      check("f_req0_len", get_len(r0 + 1), 64);

`ifdef FB_RD_TIMEOUT_EN
      // Frame G: only 5 beats delivered; timeout after 100 cycles in DATA
      beat_limit = 5;
      r0 = req_cnt;
      pulse_load();
      n = 0;
      while (timeout_err !== 1'b1 && n < 400) begin tick(); n++; end
      check("g_timeout_err", timeout_err, 1'b1);
      check("g_timeout_latency", cyc - data_entry_cyc, 100);
      check("g_frame_active_low", frame_active, 1'b0);
      repeat (20) tick();
      check("g_idle_no_req", req_cnt, r0 + 1);
      check("g_words_written", frame_words, 5);
      beat_limit = 1000;
      pulse_load();
      wait_frame(8, "frame_h");
      check("h_req0_addr", get_addr(r0 + 1), 32'h0200000);
      check("h_timeout_sticky", timeout_err, 1'b1);
`else
      check("timeout_err_tied_low", timeout_err, 1'b0);
`endif

      repeat (5) tick();
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

   initial begin
      #400000;
      $display("FAIL watchdog: simulation did not finish, got running expected finished");
      $fatal(1, "watchdog");
   end

endmodule
